// File: rtl/alarm_clock_pkg.sv
// Shared types and time constants for the multi-channel alarm engine.
package alarm_clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } alarm_state_t;

  localparam int SEC_IN_MIN  = 60;
  localparam int SEC_IN_HOUR = 60 * SEC_IN_MIN;
  localparam int SEC_IN_DAY  = 24 * SEC_IN_HOUR;

  // Width of the second counters (ring and snooze timers).
  localparam int CNT_W = 16;

  // Signed hour offset folded into a 32-bit modular addend.
  function automatic logic [31:0] gmt_offset(input int gmt_hours);
    return 32'(gmt_hours * SEC_IN_HOUR);
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: state machine, stored UTC time, repeat flag, snooze budget and timer.
module alarm_channel
  import alarm_clock_pkg::*;
#(
  parameter int SNOOZE_TIME_SEC = 5,
  parameter int MAX_SNOOZES     = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  cur_time_i,
  input  logic         tick_i,
  input  logic         set_i,
  input  logic         unset_i,
  input  logic [31:0]  set_time_i,
  input  logic         set_repeat_i,
  input  logic         off_i,
  input  logic         snooze_i,
  input  logic         ring_to_i,
  input  logic         grant_i,
  output alarm_state_t state_o,
  output logic [31:0]  time_o,
  output logic         req_o,
  output logic         ring_o,
  output logic [7:0]   left_o
);

  localparam logic [7:0]       SNZ_MAX = 8'(MAX_SNOOZES);
  localparam logic [CNT_W-1:0] SNZ_LEN = CNT_W'(SNOOZE_TIME_SEC);
  localparam logic [31:0]      DAY     = 32'(SEC_IN_DAY);

  alarm_state_t     state_q;
  logic [31:0]      time_q;
  logic             rep_q;
  logic             pend_q;
  logic [7:0]       scnt_q;
  logic [CNT_W-1:0] snz_q;

  logic stop_evt;

  // A snooze request with no budget left ends the event just like off.
  assign stop_evt = off_i || ((snooze_i || ring_to_i) && (scnt_q >= SNZ_MAX));

  assign state_o = state_q;
  assign time_o  = time_q;
  // Pending is set after a snooze expires: ring again regardless of the stored time.
  assign req_o   = (state_q == ST_ARMED) && (pend_q || (cur_time_i >= time_q));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      time_q  <= '0;
      rep_q   <= 1'b0;
      pend_q  <= 1'b0;
      scnt_q  <= '0;
      snz_q   <= '0;
      ring_o  <= 1'b0;
      left_o  <= '0;
    end else begin
      if (state_q != ST_SNOOZE) snz_q <= '0;
      else if (tick_i)          snz_q <= snz_q + 1'b1;

      if (unset_i) begin
        state_q <= ST_IDLE;
        pend_q  <= 1'b0;
        ring_o  <= 1'b0;
      end else if (set_i) begin
        state_q <= ST_ARMED;
        time_q  <= set_time_i;
        rep_q   <= set_repeat_i;
        scnt_q  <= '0;
        pend_q  <= 1'b0;
        ring_o  <= 1'b0;
      end else begin
        case (state_q)
          ST_ARMED: if (grant_i) begin
            state_q <= ST_RINGING;
            pend_q  <= 1'b0;
            ring_o  <= 1'b1;
            left_o  <= SNZ_MAX - scnt_q;
          end
          ST_RINGING: if (stop_evt) begin
            ring_o <= 1'b0;
            if (rep_q) begin
              state_q <= ST_ARMED;
              time_q  <= time_q + DAY;
              scnt_q  <= '0;
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (snooze_i || ring_to_i) begin
            state_q <= ST_SNOOZE;
            scnt_q  <= scnt_q + 8'd1;
            ring_o  <= 1'b0;
          end
          ST_SNOOZE: if (snz_q >= SNZ_LEN) begin
            state_q <= ST_ARMED;
            pend_q  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/multi_alarm_clock.sv
// N-channel alarm engine: channel array, lowest-index ring arbiter, shared ring timer, readback.
module multi_alarm_clock
  import alarm_clock_pkg::*;
#(
  parameter int NUM_ALARMS      = 4,
  parameter int GMT             = 3,
  parameter int ALARM_TIME_SEC  = 10,
  parameter int SNOOZE_TIME_SEC = 5,
  parameter int MAX_SNOOZES     = 3,
  parameter int IDX_W           = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      cur_posix_time_i,
  input  logic             last_tick_i,
  input  logic             set_en_i,
  input  logic [IDX_W-1:0] set_idx_i,
  input  logic [31:0]      set_time_i,
  input  logic             set_repeat_i,
  input  logic             unset_i,
  input  logic             off_stb_i,
  input  logic             snooze_stb_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [31:0]      rd_time_o,
  output logic             rd_armed_o,
  output logic             alarm_o,
  output logic [IDX_W-1:0] active_idx_o,
  output logic [7:0]       snooze_left_o
);

  localparam logic [31:0]      GMT_OFS  = gmt_offset(GMT);
  localparam logic [CNT_W-1:0] RING_LEN = CNT_W'(ALARM_TIME_SEC);

  logic [NUM_ALARMS-1:0]        req, grant, ring;
  logic [NUM_ALARMS-1:0][31:0]  ch_time;
  logic [NUM_ALARMS-1:0][7:0]   ch_left;
  alarm_state_t                 ch_state [NUM_ALARMS];

  logic [31:0]      set_time_utc;
  logic [CNT_W-1:0] ring_cnt;
  logic             ring_to;
  logic [IDX_W-1:0] ring_idx, last_idx_q;

  assign set_time_utc = set_time_i + GMT_OFS;

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
    alarm_channel #(
      .SNOOZE_TIME_SEC (SNOOZE_TIME_SEC),
      .MAX_SNOOZES     (MAX_SNOOZES)
    ) u_ch (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .cur_time_i   (cur_posix_time_i),
      .tick_i       (last_tick_i),
      .set_i        (set_en_i && (set_idx_i == IDX_W'(i))),
      .unset_i      (unset_i && (set_idx_i == IDX_W'(i))),
      .set_time_i   (set_time_utc),
      .set_repeat_i (set_repeat_i),
      .off_i        (off_stb_i),
      .snooze_i     (snooze_stb_i),
      .ring_to_i    (ring_to),
      .grant_i      (grant[i]),
      .state_o      (ch_state[i]),
      .time_o       (ch_time[i]),
      .req_o        (req[i]),
      .ring_o       (ring[i]),
      .left_o       (ch_left[i])
    );
  end

  // Ring flops are one-hot across channels, so alarm_o is their OR.
  assign alarm_o = |ring;
  assign ring_to = alarm_o && (ring_cnt >= RING_LEN);

  // Grant only while silent; unchosen requesters keep their request for a later round.
  always_comb begin
    grant = '0;
    if (!alarm_o) begin
      for (int i = NUM_ALARMS - 1; i >= 0; i--)
        if (req[i]) grant = NUM_ALARMS'(1) << i;
    end
  end

  always_comb begin
    ring_idx = '0;
    for (int i = 0; i < NUM_ALARMS; i++)
      if (ring[i]) ring_idx = IDX_W'(i);
  end

  assign active_idx_o = alarm_o ? ring_idx : last_idx_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ring_cnt   <= '0;
      last_idx_q <= '0;
    end else begin
      if (!alarm_o)         ring_cnt <= '0;
      else if (last_tick_i) ring_cnt <= ring_cnt + 1'b1;
      if (alarm_o) last_idx_q <= ring_idx;
    end
  end

  // Index-compare muxes so out-of-range selects read back as zero.
  always_comb begin
    snooze_left_o = '0;
    rd_time_o     = '0;
    rd_armed_o    = 1'b0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (active_idx_o == IDX_W'(i)) snooze_left_o = ch_left[i];
      if (rd_idx_i == IDX_W'(i)) begin
        rd_time_o  = ch_time[i];
        rd_armed_o = (ch_state[i] != ST_IDLE);
      end
    end
  end

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Scenario bench for multi_alarm_clock with a small arithmetic reference model.
module tb_multi_alarm_clock;

  localparam int N       = 5;
  localparam int IW      = 3;
  localparam int TB_GMT  = 3;
  localparam int RING_S  = 10;
  localparam int SNZ_S   = 5;
  localparam int MAX_SNZ = 3;
  localparam int DAY     = 86400;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [31:0]   cur_posix_time_i;
  logic          last_tick_i, set_en_i, set_repeat_i, unset_i, off_stb_i, snooze_stb_i;
  logic [IW-1:0] set_idx_i, rd_idx_i;
  logic [31:0]   set_time_i, rd_time_o;
  logic          rd_armed_o, alarm_o;
  logic [IW-1:0] active_idx_o;
  logic [7:0]    snooze_left_o;

  int errors = 0;
  int checks = 0;

  multi_alarm_clock #(
    .NUM_ALARMS(N), .GMT(TB_GMT), .ALARM_TIME_SEC(RING_S),
    .SNOOZE_TIME_SEC(SNZ_S), .MAX_SNOOZES(MAX_SNZ), .IDX_W(IW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cur_posix_time_i(cur_posix_time_i),
    .last_tick_i(last_tick_i), .set_en_i(set_en_i), .set_idx_i(set_idx_i),
    .set_time_i(set_time_i), .set_repeat_i(set_repeat_i), .unset_i(unset_i),
    .off_stb_i(off_stb_i), .snooze_stb_i(snooze_stb_i), .rd_idx_i(rd_idx_i),
    .rd_time_o(rd_time_o), .rd_armed_o(rd_armed_o), .alarm_o(alarm_o),
    .active_idx_o(active_idx_o), .snooze_left_o(snooze_left_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] utc_of(input logic [31:0] t);
    return t + 32'(TB_GMT * 3600);
  endfunction

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic tick();
    last_tick_i = 1'b1; step(); last_tick_i = 1'b0;
  endtask

  task automatic set_alarm(input int idx, input logic [31:0] t, input logic rep);
    set_en_i = 1'b1; set_idx_i = IW'(idx); set_time_i = t; set_repeat_i = rep;
    step();
    set_en_i = 1'b0; set_repeat_i = 1'b0;
  endtask

  task automatic unset_ch(input int idx);
    unset_i = 1'b1; set_idx_i = IW'(idx); step(); unset_i = 1'b0;
  endtask

  task automatic pulse_off();
    off_stb_i = 1'b1; step(); off_stb_i = 1'b0;
  endtask

  task automatic pulse_snooze();
    snooze_stb_i = 1'b1; step(); snooze_stb_i = 1'b0;
  endtask

  task automatic wait_alarm(input logic val, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < max_cyc; n++) begin
      step();
      if (alarm_o === val) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; cur_posix_time_i = '0; last_tick_i = 0; set_en_i = 0; set_repeat_i = 0;
    unset_i = 0; off_stb_i = 0; snooze_stb_i = 0; set_idx_i = '0; rd_idx_i = '0; set_time_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if (alarm_o !== 1'b0) begin errors++; $display("FAIL reset_alarm got=%0b want=0", alarm_o); end
    checks++; if (active_idx_o !== '0) begin errors++; $display("FAIL reset_idx got=%0d want=0", active_idx_o); end
    checks++; if (snooze_left_o !== 8'd0) begin errors++; $display("FAIL reset_left got=%0d want=0", snooze_left_o); end
    for (int i = 0; i < 8; i++) begin
      rd_idx_i = IW'(i); #1;
      checks++; if (rd_time_o !== 32'd0 || rd_armed_o !== 1'b0) begin
        errors++; $display("FAIL reset_rd ch%0d got time=%0h armed=%0b want 0/0", i, rd_time_o, rd_armed_o);
      end
    end
    @(posedge clk_i); #1; rst_i = 1'b0;
    step();
  endtask

  task automatic test_readback_random();
    logic [31:0] exp_t [8];
    bit          exp_a [8];
    int idx;
    logic [31:0] t;
    for (int i = 0; i < 8; i++) begin exp_t[i] = '0; exp_a[i] = 1'b0; end
    for (int it = 0; it < 24; it++) begin
      idx = $urandom_range(0, 7);
      t   = $urandom_range(32'h7FFF0000, 100000);
      if ($urandom_range(0, 3) == 0) begin
        unset_ch(idx);
        if (idx < N) exp_a[idx] = 1'b0;
      end else begin
        set_alarm(idx, t, 1'b0);
        if (idx < N) begin exp_t[idx] = utc_of(t); exp_a[idx] = 1'b1; end
      end
      for (int i = 0; i < 8; i++) begin
        rd_idx_i = IW'(i); #1;
        checks++; if (rd_time_o !== exp_t[i] || rd_armed_o !== exp_a[i]) begin
          errors++; $display("FAIL rand_rd ch%0d got time=%0h armed=%0b want time=%0h armed=%0b",
                             i, rd_time_o, rd_armed_o, exp_t[i], exp_a[i]);
        end
      end
    end
    set_alarm(4, 32'hFFFF_F000, 1'b0);
    rd_idx_i = 3'd4; #1;
    checks++; if (rd_time_o !== 32'h0000_1A30) begin
      errors++; $display("FAIL wrap_time got=%0h want=00001a30", rd_time_o);
    end
    for (int i = 0; i < N; i++) unset_ch(i);
    checks++; if (alarm_o !== 1'b0) begin errors++; $display("FAIL rand_quiet alarm got=%0b want=0", alarm_o); end
  endtask

  task automatic test_ring_snooze();
    bit ok;
    int left;
    set_alarm(0, 32'd1000, 1'b0);
    rd_idx_i = '0; #1;
    checks++; if (rd_time_o !== 32'd11800) begin errors++; $display("FAIL gmt_time got=%0d want=11800", rd_time_o); end
    cur_posix_time_i = 32'd11799; step(); step();
    checks++; if (alarm_o !== 1'b0) begin errors++; $display("FAIL early_ring got=%0b want=0", alarm_o); end
    cur_posix_time_i = 32'd11800; step();
    checks++; if (alarm_o !== 1'b1 || active_idx_o !== 3'd0 || snooze_left_o !== 8'(MAX_SNZ)) begin
      errors++; $display("FAIL ring_start got alarm=%0b idx=%0d left=%0d want 1/0/%0d",
                         alarm_o, active_idx_o, snooze_left_o, MAX_SNZ);
    end
    left = MAX_SNZ;
    for (int r = 0; r <= MAX_SNZ; r++) begin
      repeat (RING_S - 1) tick();
      step();
      checks++; if (alarm_o !== 1'b1) begin errors++; $display("FAIL ring_hold r%0d got=%0b want=1", r, alarm_o); end
      tick();
      wait_alarm(1'b0, 4, ok);
      checks++; if (!ok) begin errors++; $display("FAIL ring_timeout r%0d alarm stayed=%0b want=0", r, alarm_o); end
      if (left > 0) begin
        left--;
        repeat (SNZ_S - 1) tick();
        step(); step();
        checks++; if (alarm_o !== 1'b0) begin errors++; $display("FAIL snooze_hold r%0d got=%0b want=0", r, alarm_o); end
        tick();
        wait_alarm(1'b1, 4, ok);
        checks++; if (!ok || active_idx_o !== 3'd0 || snooze_left_o !== 8'(left)) begin
          errors++; $display("FAIL re_ring r%0d got alarm=%0b idx=%0d left=%0d want 1/0/%0d",
                             r, alarm_o, active_idx_o, snooze_left_o, left);
        end
      end
    end
    repeat (SNZ_S + 2) tick();
    rd_idx_i = '0; #1;
    checks++; if (alarm_o !== 1'b0 || rd_armed_o !== 1'b0) begin
      errors++; $display("FAIL budget_done got alarm=%0b armed=%0b want 0/0", alarm_o, rd_armed_o);
    end
  endtask

  task automatic test_repeat_off();
    bit ok;
    cur_posix_time_i = 32'd20000;
    set_alarm(1, 32'd9200, 1'b1);
    wait_alarm(1'b1, 4, ok);
    checks++; if (!ok || active_idx_o !== 3'd1) begin
      errors++; $display("FAIL rep_ring got alarm=%0b idx=%0d want 1/1", alarm_o, active_idx_o);
    end
    pulse_off();
    rd_idx_i = 3'd1; #1;
    checks++; if (alarm_o !== 1'b0) begin errors++; $display("FAIL rep_off got=%0b want=0", alarm_o); end
    checks++; if (rd_time_o !== utc_of(32'd9200) + 32'(DAY) || rd_armed_o !== 1'b1) begin
      errors++; $display("FAIL rep_rearm got time=%0d armed=%0b want time=%0d armed=1",
                         rd_time_o, rd_armed_o, utc_of(32'd9200) + 32'(DAY));
    end
    repeat (3) step();
    checks++; if (alarm_o !== 1'b0) begin errors++; $display("FAIL rep_quiet got=%0b want=0", alarm_o); end
    unset_ch(1);
  endtask

  task automatic test_back_to_back();
    set_alarm(0, 32'd30000, 1'b0);
    set_alarm(2, 32'd30000, 1'b0);
    step();
    checks++; if (alarm_o !== 1'b0) begin errors++; $display("FAIL arb_early got=%0b want=0", alarm_o); end
    cur_posix_time_i = utc_of(32'd30000);
    step();
    checks++; if (alarm_o !== 1'b1 || active_idx_o !== 3'd0) begin
      errors++; $display("FAIL arb_first got alarm=%0b idx=%0d want 1/0", alarm_o, active_idx_o);
    end
    pulse_off();
    checks++; if (alarm_o !== 1'b0) begin errors++; $display("FAIL arb_off got=%0b want=0", alarm_o); end
    step();
    checks++; if (alarm_o !== 1'b1 || active_idx_o !== 3'd2) begin
      errors++; $display("FAIL arb_second got alarm=%0b idx=%0d want 1/2", alarm_o, active_idx_o);
    end
    pulse_off();
    rd_idx_i = 3'd2; #1;
    checks++; if (alarm_o !== 1'b0 || rd_armed_o !== 1'b0) begin
      errors++; $display("FAIL arb_done got alarm=%0b armed=%0b want 0/0", alarm_o, rd_armed_o);
    end
  endtask

  task automatic test_snooze_random();
    bit ok, done;
    int left, act;
    set_alarm(2, cur_posix_time_i - 32'(TB_GMT * 3600), 1'b0);
    wait_alarm(1'b1, 4, ok);
    left = MAX_SNZ; done = 1'b0;
    for (int it = 0; it < 8 && !done; it++) begin
      checks++; if (alarm_o !== 1'b1 || active_idx_o !== 3'd2 || snooze_left_o !== 8'(left)) begin
        errors++; $display("FAIL rsnz_ring it%0d got alarm=%0b idx=%0d left=%0d want 1/2/%0d",
                           it, alarm_o, active_idx_o, snooze_left_o, left);
      end
      act = $urandom_range(0, 2);
      if (act == 1) begin
        pulse_off(); done = 1'b1;
      end else begin
        if (act == 0) pulse_snooze();
        else repeat (RING_S) tick();
        wait_alarm(1'b0, 4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rsnz_stop it%0d act%0d alarm=%0b want=0", it, act, alarm_o); end
        if (left == 0) done = 1'b1;
        else begin
          left--;
          repeat (SNZ_S) tick();
          wait_alarm(1'b1, 4, ok);
        end
      end
    end
    if (!done) pulse_off();
    step();
    rd_idx_i = 3'd2; #1;
    checks++; if (alarm_o !== 1'b0 || rd_armed_o !== 1'b0) begin
      errors++; $display("FAIL rsnz_end got alarm=%0b armed=%0b want 0/0", alarm_o, rd_armed_o);
    end
  endtask

  task automatic test_set_unset();
    bit ok;
    set_alarm(3, 32'd900000, 1'b0);
    set_en_i = 1'b1; unset_i = 1'b1; set_idx_i = 3'd3; set_time_i = 32'd1234;
    step();
    set_en_i = 1'b0; unset_i = 1'b0;
    rd_idx_i = 3'd3; #1;
    checks++; if (rd_armed_o !== 1'b0) begin errors++; $display("FAIL set_unset armed=%0b want=0", rd_armed_o); end
    set_alarm(3, cur_posix_time_i - 32'(TB_GMT * 3600), 1'b0);
    wait_alarm(1'b1, 4, ok);
    checks++; if (!ok || active_idx_o !== 3'd3) begin
      errors++; $display("FAIL ch3_ring got alarm=%0b idx=%0d want 1/3", alarm_o, active_idx_o);
    end
    unset_ch(3);
    #1;
    checks++; if (alarm_o !== 1'b0 || rd_armed_o !== 1'b0) begin
      errors++; $display("FAIL unset_ring got alarm=%0b armed=%0b want 0/0", alarm_o, rd_armed_o);
    end
  endtask

  task automatic test_set_during_ring();
    bit ok;
    set_alarm(4, cur_posix_time_i - 32'(TB_GMT * 3600), 1'b0);
    wait_alarm(1'b1, 4, ok);
    set_alarm(4, 32'd500000, 1'b0);
    rd_idx_i = 3'd4; #1;
    checks++; if (alarm_o !== 1'b0 || rd_armed_o !== 1'b1 || rd_time_o !== utc_of(32'd500000)) begin
      errors++; $display("FAIL set_abort got alarm=%0b armed=%0b time=%0d want 0/1/%0d",
                         alarm_o, rd_armed_o, rd_time_o, utc_of(32'd500000));
    end
    pulse_off(); pulse_snooze(); repeat (3) step();
    checks++; if (alarm_o !== 1'b0 || rd_armed_o !== 1'b1) begin
      errors++; $display("FAIL idle_strobes got alarm=%0b armed=%0b want 0/1", alarm_o, rd_armed_o);
    end
    unset_ch(4);
  endtask

  task automatic test_reset_ring();
    bit ok;
    set_alarm(1, 32'd900000, 1'b0);
    set_alarm(0, cur_posix_time_i - 32'(TB_GMT * 3600), 1'b0);
    wait_alarm(1'b1, 4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pre_reset_ring alarm=%0b want=1", alarm_o); end
    #2 rst_i = 1'b1;
    #1;
    checks++; if (alarm_o !== 1'b0) begin errors++; $display("FAIL async_reset alarm=%0b want=0", alarm_o); end
    for (int i = 0; i < N; i++) begin
      rd_idx_i = IW'(i); #1;
      checks++; if (rd_armed_o !== 1'b0) begin errors++; $display("FAIL reset_armed ch%0d got=%0b want=0", i, rd_armed_o); end
    end
    @(posedge clk_i); #1; rst_i = 1'b0;
    step(); step();
    checks++; if (alarm_o !== 1'b0) begin errors++; $display("FAIL post_reset alarm=%0b want=0", alarm_o); end
  endtask

  initial begin
    test_reset();
    test_readback_random();
    test_ring_snooze();
    test_repeat_off();
    test_back_to_back();
    test_snooze_random();
    test_set_unset();
    test_set_during_ring();
    test_reset_ring();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
